// File: rtl/cby_pkg.sv
// Shared definitions for the vertical connection block: default sizes and
// the track-pattern / select-width helpers used when building pin muxes.
// Pure compile-time content; no logic or state.
package cby_pkg;

   localparam int CBY_CHAN_W     = 9;
   localparam int CBY_NUM_IPIN   = 10;
   localparam int CBY_MUX_SIZE   = 6;
   localparam int CBY_TRACK_STEP = 4;

   // Track feeding candidate pair j of pin p; pairs walk the channel in
   // steps of 'step' and wrap so every pin sees a spread of tracks.
   function automatic int cby_track_idx(input int p, input int j,
                                        input int chan_w, input int step);
      return (p + j * step) % chan_w;
   endfunction

   // Select bits needed for a mux of mux_size inputs (at least 1).
   function automatic int cby_sel_w(input int mux_size);
      return (mux_size <= 2) ? 1 : $clog2(mux_size);
   endfunction

endpackage

// File: rtl/cby_ipin_mux.sv
// Purpose: MUX_SIZE:1 pin selector; selects beyond MUX_SIZE or en=0 give 0.
// Latency: purely combinational.
// Backpressure: none; output follows cand/sel/en continuously.
// Ports: cand (candidate tracks), sel (select field), en (config valid), y (pin drive).
module cby_ipin_mux #(
   parameter int MUX_SIZE = 6,
   parameter int SEL_W    = 3
) (
   input  logic [MUX_SIZE-1:0] cand,
   input  logic [SEL_W-1:0]    sel,
   input  logic                en,
   output logic                y
);

   // Matching against each legal index means unused select codes never
   // match and fall through to the zero default.
   always_comb begin
      y = 1'b0;
      if (en) begin
         for (int k = 0; k < MUX_SIZE; k++) begin
            if (sel == SEL_W'(k)) begin
               y = cand[k];
            end
         end
      end
   end

endmodule

// File: rtl/cby_param_dbuf.sv
// Purpose: vertical connection block, track pass-through plus NUM_IPIN pin muxes
//          configured through a double-buffered (shadow/active) serial chain.
// Latency: pass-through and pin muxes combinational; chain 1 prog_clk per stage.
// Backpressure: none; a commit without exactly TOTAL shifted bits is dropped and flagged.
// Ports: prog_clk/prog_reset_n (sync, active-low); chany_{bottom,top}_{in,out} tracks;
//        ccff_head/en/commit/tail config chain; ipin_out pins; cfg_valid/full/err status.
module cby_param_dbuf
   import cby_pkg::*;
#(
   parameter int CHAN_W     = CBY_CHAN_W,
   parameter int NUM_IPIN   = CBY_NUM_IPIN,
   parameter int MUX_SIZE   = CBY_MUX_SIZE,
   parameter int TRACK_STEP = CBY_TRACK_STEP,
   parameter int SEL_W      = cby_sel_w(MUX_SIZE),
   parameter int TOTAL      = NUM_IPIN * SEL_W
) (
   input  logic                prog_clk,
   input  logic                prog_reset_n,
   input  logic [CHAN_W-1:0]   chany_bottom_in,
   input  logic [CHAN_W-1:0]   chany_top_in,
   output logic [CHAN_W-1:0]   chany_bottom_out,
   output logic [CHAN_W-1:0]   chany_top_out,
   input  logic                ccff_head,
   input  logic                ccff_en,
   input  logic                ccff_commit,
   output logic                ccff_tail,
   output logic [NUM_IPIN-1:0] ipin_out,
   output logic                cfg_valid,
   output logic                cfg_full,
   output logic                cfg_err
);

   // Counter must reach TOTAL+1, the saturated "too many bits" value.
   localparam int CNT_W = $clog2(TOTAL + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TOTAL + 1);

   logic [TOTAL-1:0] shadow;
   logic [TOTAL-1:0] active;
   logic [CNT_W-1:0] bit_cnt;

   assign chany_bottom_out = chany_top_in;
   assign chany_top_out    = chany_bottom_in;

   assign ccff_tail = shadow[TOTAL-1];
   assign cfg_full  = (bit_cnt == CNT_FULL);

   always_ff @(posedge prog_clk) begin
      if (!prog_reset_n) begin
         shadow    <= '0;
         active    <= '0;
         bit_cnt   <= '0;
         cfg_valid <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         if (ccff_en) begin
            shadow <= {shadow[TOTAL-2:0], ccff_head};
         end
         if (ccff_commit && cfg_full) begin
            // active takes the pre-shift shadow; a same-cycle shift bit
            // is the first bit of the next load, hence count restarts at 1.
            active    <= shadow;
            cfg_valid <= 1'b1;
            bit_cnt   <= ccff_en ? CNT_W'(1) : '0;
         end else begin
            if (ccff_commit) begin
               cfg_err <= 1'b1;
            end
            if (ccff_en && (bit_cnt != CNT_SAT)) begin
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
         end
      end
   end

   for (genvar p = 0; p < NUM_IPIN; p++) begin : g_pin
      logic [MUX_SIZE-1:0] cand;

      // Even candidates come from the bottom track, odd from the top track
      // of the same index, so each pair covers both directions.
      for (genvar k = 0; k < MUX_SIZE; k++) begin : g_cand
         localparam int T = cby_track_idx(p, k / 2, CHAN_W, TRACK_STEP);
         if (k % 2 == 0) begin : g_even
            assign cand[k] = chany_bottom_in[T];
         end else begin : g_odd
            assign cand[k] = chany_top_in[T];
         end
      end

      cby_ipin_mux #(
         .MUX_SIZE (MUX_SIZE),
         .SEL_W    (SEL_W)
      ) u_mux (
         .cand (cand),
         .sel  (active[p*SEL_W +: SEL_W]),
         .en   (cfg_valid),
         .y    (ipin_out[p])
      );
   end

endmodule

// File: tb/tb_cby_param_dbuf.sv
module tb_cby_param_dbuf;

   logic       prog_clk;
   logic       prog_reset_n;
   logic [8:0] chany_bottom_in;
   logic [8:0] chany_top_in;
   logic [8:0] chany_bottom_out;
   logic [8:0] chany_top_out;
   logic       ccff_head;
   logic       ccff_en;
   logic       ccff_commit;
   logic       ccff_tail;
   logic [9:0] ipin_out;
   logic       cfg_valid;
   logic       cfg_full;
   logic       cfg_err;

   int vec_cnt  = 0;
   int mis_cnt  = 0;

   cby_param_dbuf dut (
      .prog_clk         (prog_clk),
      .prog_reset_n     (prog_reset_n),
      .chany_bottom_in  (chany_bottom_in),
      .chany_top_in     (chany_top_in),
      .chany_bottom_out (chany_bottom_out),
      .chany_top_out    (chany_top_out),
      .ccff_head        (ccff_head),
      .ccff_en          (ccff_en),
      .ccff_commit      (ccff_commit),
      .ccff_tail        (ccff_tail),
      .ipin_out         (ipin_out),
      .cfg_valid        (cfg_valid),
      .cfg_full         (cfg_full),
      .cfg_err          (cfg_err)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   task automatic clk_edge();
      @(posedge prog_clk);
      #1;
   endtask

   // Shift v[n-1] first and v[0] last, so v[2:0] ends up as pin 0's select.
   task automatic shift_bits(input logic [29:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         ccff_head = v[i];
         ccff_en   = 1'b1;
         clk_edge();
      end
      ccff_en   = 1'b0;
      ccff_head = 1'b0;
   endtask

   task automatic do_commit();
      ccff_commit = 1'b1;
      clk_edge();
      ccff_commit = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      prog_reset_n = 1'b0;
      clk_edge();
      prog_reset_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      chany_bottom_in = 9'h1AA;
      chany_top_in    = 9'h055;
      #1;
      vec_cnt++;
      if (chany_top_out !== 9'h1AA) begin
         mis_cnt++; $display("FAIL reset_top_out got %h want 1aa", chany_top_out);
      end
      vec_cnt++;
      if (chany_bottom_out !== 9'h055) begin
         mis_cnt++; $display("FAIL reset_bottom_out got %h want 055", chany_bottom_out);
      end
      vec_cnt++;
      if (ipin_out !== 10'h000) begin
         mis_cnt++; $display("FAIL reset_ipin got %h want 000", ipin_out);
      end
      vec_cnt++;
      if ({cfg_valid, cfg_full, cfg_err, ccff_tail} !== 4'b0000) begin
         mis_cnt++; $display("FAIL reset_flags got v%b f%b e%b t%b want all 0",
                              cfg_valid, cfg_full, cfg_err, ccff_tail);
      end
   endtask

   // pin0 sel=4 -> bottom[8], pin1 sel=3 -> top[5], other pins sel=0 -> bottom[p]
   task automatic test_commit();
      chany_bottom_in = 9'h100;
      chany_top_in    = 9'h020;
      shift_bits(30'h0000001C, 30);
      vec_cnt++;
      if (cfg_full !== 1'b1) begin
         mis_cnt++; $display("FAIL commit_full_before got %b want 1", cfg_full);
      end
      vec_cnt++;
      if (ipin_out !== 10'h000) begin
         mis_cnt++; $display("FAIL commit_ipin_before got %h want 000", ipin_out);
      end
      do_commit();
      vec_cnt++;
      if (ipin_out !== 10'h103) begin
         mis_cnt++; $display("FAIL commit_ipin got %h want 103", ipin_out);
      end
      vec_cnt++;
      if ({cfg_valid, cfg_full, cfg_err} !== 3'b100) begin
         mis_cnt++; $display("FAIL commit_flags got v%b f%b e%b want v1 f0 e0",
                              cfg_valid, cfg_full, cfg_err);
      end
      chany_bottom_in = 9'h0FF;
      chany_top_in    = 9'h000;
      #1;
      vec_cnt++;
      if (ipin_out !== 10'h2FC) begin
         mis_cnt++; $display("FAIL commit_ipin_pat2 got %h want 2fc", ipin_out);
      end
      chany_bottom_in = 9'h100;
      chany_top_in    = 9'h020;
      #1;
   endtask

   // New word: pin0 sel=1 -> top[0]; delivered as 29 bits, early commit, then 1 bit.
   task automatic test_short_commit();
      shift_bits(30'h00000000, 29);
      do_commit();
      vec_cnt++;
      if (cfg_err !== 1'b1) begin
         mis_cnt++; $display("FAIL short_err got %b want 1", cfg_err);
      end
      vec_cnt++;
      if (ipin_out !== 10'h103) begin
         mis_cnt++; $display("FAIL short_ipin_kept got %h want 103", ipin_out);
      end
      shift_bits(30'h00000001, 1);
      vec_cnt++;
      if (cfg_full !== 1'b1) begin
         mis_cnt++; $display("FAIL short_full_30 got %b want 1", cfg_full);
      end
      do_commit();
      chany_top_in = 9'h001;
      #1;
      vec_cnt++;
      if (ipin_out !== 10'h101) begin
         mis_cnt++; $display("FAIL short_ipin_new got %h want 101", ipin_out);
      end
      vec_cnt++;
      if ({cfg_valid, cfg_err} !== 2'b11) begin
         mis_cnt++; $display("FAIL short_err_sticky got v%b e%b want v1 e1",
                              cfg_valid, cfg_err);
      end
   endtask

   // pin2 sel=7 is out of range; all others sel=0 -> bottom[p mod 9].
   task automatic test_out_of_range();
      shift_bits(30'h000001C0, 30);
      do_commit();
      chany_bottom_in = 9'h1FF;
      chany_top_in    = 9'h1FF;
      #1;
      vec_cnt++;
      if (ipin_out !== 10'h3FB) begin
         mis_cnt++; $display("FAIL oor_ipin_ones got %h want 3fb", ipin_out);
      end
      chany_bottom_in = 9'h004;
      chany_top_in    = 9'h000;
      #1;
      vec_cnt++;
      if (ipin_out !== 10'h000) begin
         mis_cnt++; $display("FAIL oor_ipin_b2 got %h want 000", ipin_out);
      end
   endtask

   // Commit while shifting: active takes the pre-shift word, count restarts at 1.
   task automatic test_back_to_back();
      shift_bits(30'h00000005, 30);
      chany_bottom_in = 9'h000;
      chany_top_in    = 9'h100;
      ccff_commit = 1'b1;
      ccff_en     = 1'b1;
      ccff_head   = 1'b1;
      clk_edge();
      ccff_commit = 1'b0;
      ccff_en     = 1'b0;
      ccff_head   = 1'b0;
      #1;
      vec_cnt++;
      if (ipin_out !== 10'h001) begin
         mis_cnt++; $display("FAIL b2b_ipin got %h want 001", ipin_out);
      end
      vec_cnt++;
      if (cfg_full !== 1'b0) begin
         mis_cnt++; $display("FAIL b2b_full_after got %b want 0", cfg_full);
      end
      shift_bits(30'h00000000, 28);
      vec_cnt++;
      if (cfg_full !== 1'b0) begin
         mis_cnt++; $display("FAIL b2b_full_29 got %b want 0", cfg_full);
      end
      shift_bits(30'h00000000, 1);
      vec_cnt++;
      if (cfg_full !== 1'b1) begin
         mis_cnt++; $display("FAIL b2b_full_30 got %b want 1", cfg_full);
      end
   endtask

   // From a clean shadow, 30 ones then 30 zeros: the tail sits at stage 30,
   // so it reads 1 after edges 30..59 and 0 otherwise.
   task automatic test_tail_saturate();
      do_reset();
      for (int e = 1; e <= 60; e++) begin
         ccff_head = (e <= 30);
         ccff_en   = 1'b1;
         clk_edge();
         vec_cnt++;
         if (ccff_tail !== ((e >= 30) && (e <= 59))) begin
            mis_cnt++; $display("FAIL tail_edge%0d got %b want %b", e, ccff_tail,
                                 ((e >= 30) && (e <= 59)));
         end
         if (e == 30) begin
            vec_cnt++;
            if (cfg_full !== 1'b1) begin
               mis_cnt++; $display("FAIL tail_full_30 got %b want 1", cfg_full);
            end
         end
         if (e == 31) begin
            vec_cnt++;
            if (cfg_full !== 1'b0) begin
               mis_cnt++; $display("FAIL tail_full_31 got %b want 0", cfg_full);
            end
         end
      end
      ccff_en   = 1'b0;
      ccff_head = 1'b0;
      do_commit();
      vec_cnt++;
      if ({cfg_valid, cfg_full, cfg_err} !== 3'b001) begin
         mis_cnt++; $display("FAIL sat_commit got v%b f%b e%b want v0 f0 e1",
                              cfg_valid, cfg_full, cfg_err);
      end
   endtask

   task automatic test_reset_mid_shift();
      do_reset();
      chany_bottom_in = 9'h100;
      chany_top_in    = 9'h020;
      shift_bits(30'h0000001C, 30);
      do_commit();
      vec_cnt++;
      if (ipin_out !== 10'h103) begin
         mis_cnt++; $display("FAIL rst_pre_ipin got %h want 103", ipin_out);
      end
      shift_bits(30'h00000000, 30);
      prog_reset_n = 1'b0;
      ccff_en      = 1'b1;
      ccff_commit  = 1'b1;
      ccff_head    = 1'b1;
      clk_edge();
      vec_cnt++;
      if (chany_top_out !== 9'h100 || chany_bottom_out !== 9'h020) begin
         mis_cnt++; $display("FAIL rst_passthru got top %h bot %h want 100 020",
                              chany_top_out, chany_bottom_out);
      end
      prog_reset_n = 1'b1;
      ccff_en      = 1'b0;
      ccff_commit  = 1'b0;
      ccff_head    = 1'b0;
      #1;
      vec_cnt++;
      if (ipin_out !== 10'h000) begin
         mis_cnt++; $display("FAIL rst_ipin got %h want 000", ipin_out);
      end
      vec_cnt++;
      if ({cfg_valid, cfg_full, cfg_err, ccff_tail} !== 4'b0000) begin
         mis_cnt++; $display("FAIL rst_flags got v%b f%b e%b t%b want all 0",
                              cfg_valid, cfg_full, cfg_err, ccff_tail);
      end
      do_commit();
      vec_cnt++;
      if ({cfg_valid, cfg_err} !== 2'b01) begin
         mis_cnt++; $display("FAIL rst_post_commit got v%b e%b want v0 e1",
                              cfg_valid, cfg_err);
      end
   endtask

   initial begin
      prog_reset_n    = 1'b0;
      chany_bottom_in = '0;
      chany_top_in    = '0;
      ccff_head       = 1'b0;
      ccff_en         = 1'b0;
      ccff_commit     = 1'b0;
      test_reset();
      test_commit();
      test_short_commit();
      test_out_of_range();
      test_back_to_back();
      test_tail_saturate();
      test_reset_mid_shift();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
      $finish;
   end

endmodule
